// File: rtl/ultra_sonic_range_if.sv
// Sample stream in, filtered range results out, between the echo timer and register block.
interface ultra_sonic_range_if;
  logic [31:0] sample_data;
  logic        sample_valid;
  logic [15:0] distance_mm;
  logic        distance_valid;
  logic        near;
  logic        stale;
  logic        primed;
  logic [15:0] miss_count;
  logic        overrun;

  // Producer side: the echo timer stage plus whoever consumes the results.
  modport master (
    output sample_data, sample_valid,
    input  distance_mm, distance_valid, near, stale, primed, miss_count, overrun
  );

  // Filter side: the ultra_sonic_range block itself.
  modport slave (
    input  sample_data, sample_valid,
    output distance_mm, distance_valid, near, stale, primed, miss_count, overrun
  );
endinterface

// File: rtl/ultra_sonic_range.sv
// Ultrasonic range filter: rejects miss samples, averages the last 2^AVG_LOG2 good echo
// counts, scales the average to millimetres and drives a hysteretic proximity flag.
module ultra_sonic_range #(
  parameter int COUNT_WIDTH = 21,
  parameter int MAX_COUNT   = 1200000,
  parameter int AVG_LOG2    = 2,
  parameter int SCALE_NUM   = 225,
  parameter int SCALE_SHIFT = 16,
  parameter int NEAR_MM     = 300,
  parameter int FAR_MM      = 400,
  parameter int MISS_LIMIT  = 8
) (
  input  logic                clk,
  input  logic                reset,
  ultra_sonic_range_if.slave  bus
);

  localparam int N       = 1 << AVG_LOG2;
  localparam int SUM_W   = COUNT_WIDTH + AVG_LOG2;
  localparam int SCALE_W = $clog2(SCALE_NUM + 1);
  localparam int PROD_W  = COUNT_WIDTH + SCALE_W;
  localparam int EXT_W   = PROD_W + 16;
  localparam int RUN_W   = $clog2(MISS_LIMIT + 1);
  localparam int FILL_W  = AVG_LOG2 + 1;

  localparam logic [31:0]       MAX_L   = 32'(MAX_COUNT);
  localparam logic [15:0]       NEAR_L  = 16'(NEAR_MM);
  localparam logic [15:0]       FAR_L   = 16'(FAR_MM);
  localparam logic [RUN_W-1:0]  LIMIT_L = RUN_W'(MISS_LIMIT);
  localparam logic [FILL_W-1:0] FULL_L  = FILL_W'(N);

  typedef enum logic [1:0] {IDLE, ACC, MUL, OUT} state_e;

  state_e                  state_q, state_d;
  logic [COUNT_WIDTH-1:0]  new_q, new_d;
  logic [COUNT_WIDTH-1:0]  win_q [N];
  logic [COUNT_WIDTH-1:0]  win_d [N];
  logic [AVG_LOG2-1:0]     wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0]       fill_q, fill_d;
  logic [SUM_W-1:0]        sum_q, sum_d;
  logic [PROD_W-1:0]       prod_q, prod_d;
  logic [15:0]             dist_q, dist_d;
  logic                    dv_q, dv_d;
  logic                    near_q, near_d;
  logic                    stale_q, stale_d;
  logic [15:0]             miss_cnt_q, miss_cnt_d;
  logic [RUN_W-1:0]        run_q, run_d;
  logic                    overrun_q, overrun_d;

  logic                    is_miss;
  logic                    primed;
  logic [EXT_W-1:0]        scaled;
  logic [15:0]             dist_sat;

  assign is_miss  = (bus.sample_data == 32'd0) || (bus.sample_data >= MAX_L);
  assign primed   = (fill_q == FULL_L);
  assign scaled   = EXT_W'(prod_q) >> SCALE_SHIFT;
  assign dist_sat = (scaled > EXT_W'(16'hFFFF)) ? 16'hFFFF : scaled[15:0];

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: only IDLE accepts a good sample; the pipeline then runs one pass unconditionally.
  always_comb begin
    // NOTE: a default assignment before any branch keeps combinational logic latch-free.
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.sample_valid && !is_miss) state_d = ACC;
      ACC:  state_d = MUL;
      MUL:  state_d = OUT;
      OUT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath: miss bookkeeping, running-sum window update, scaling and hysteresis.
  always_comb begin
    new_d      = new_q;
    win_d      = win_q;
    wr_ptr_d   = wr_ptr_q;
    fill_d     = fill_q;
    sum_d      = sum_q;
    prod_d     = prod_q;
    dist_d     = dist_q;
    dv_d       = 1'b0;
    near_d     = near_q;
    stale_d    = stale_q;
    miss_cnt_d = miss_cnt_q;
    run_d      = run_q;
    overrun_d  = overrun_q;

    if (bus.sample_valid && state_q != IDLE) overrun_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (bus.sample_valid) begin
          if (is_miss) begin
            if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
            if (run_q != LIMIT_L)       run_d      = run_q + RUN_W'(1);
            if (run_d == LIMIT_L) begin
              stale_d = 1'b1;
              near_d  = 1'b0;
            end
          end else begin
            new_d   = bus.sample_data[COUNT_WIDTH-1:0];
            run_d   = '0;
            stale_d = 1'b0;
          end
        end
      end
      ACC: begin
        // Swapping the oldest entry for the newest keeps the sum exact without re-adding the window.
        sum_d           = sum_q + SUM_W'(new_q) - SUM_W'(win_q[wr_ptr_q]);
        win_d[wr_ptr_q] = new_q;
        wr_ptr_d        = wr_ptr_q + AVG_LOG2'(1);
        if (fill_q != FULL_L) fill_d = fill_q + FILL_W'(1);
      end
      MUL: begin
        prod_d = PROD_W'(sum_q >> AVG_LOG2) * PROD_W'(SCALE_NUM);
      end
      OUT: begin
        if (primed) begin
          dist_d = dist_sat;
          dv_d   = 1'b1;
          if (dist_sat < NEAR_L)     near_d = 1'b1;
          else if (dist_sat > FAR_L) near_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      new_q      <= '0;
      // NOTE: the window is reset too, because the running sum assumes every entry starts at zero.
      win_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      sum_q      <= '0;
      prod_q     <= '0;
      dist_q     <= '0;
      dv_q       <= 1'b0;
      near_q     <= 1'b0;
      stale_q    <= 1'b0;
      miss_cnt_q <= '0;
      run_q      <= '0;
      overrun_q  <= 1'b0;
    end else begin
      new_q      <= new_d;
      win_q      <= win_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      sum_q      <= sum_d;
      prod_q     <= prod_d;
      dist_q     <= dist_d;
      dv_q       <= dv_d;
      near_q     <= near_d;
      stale_q    <= stale_d;
      miss_cnt_q <= miss_cnt_d;
      run_q      <= run_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.distance_mm    = dist_q;
  assign bus.distance_valid = dv_q;
  assign bus.near           = near_q;
  assign bus.stale          = stale_q;
  assign bus.primed         = primed;
  assign bus.miss_count     = miss_cnt_q;
  assign bus.overrun        = overrun_q;

endmodule

// File: tb/tb_ultra_sonic_range.sv
// Self-checking bench for ultra_sonic_range: a transaction-level model predicts every output
// each cycle, and literal expectations pin the headline distances and flag transitions.
module tb_ultra_sonic_range;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;

  ultra_sonic_range_if bus();

  ultra_sonic_range dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int pulses = 0;
  int last_pulse_cyc = -1;
  int send_cyc = 0;

  // Model state: window contents, fill level, pending sample and a countdown to its result.
  longint win [N];
  int     wp, fill, busy;
  longint pend;
  int     m_dist, m_miss, m_run;
  bit     m_dv, m_near, m_stale, m_over;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) win[i] = 0;
    wp = 0; fill = 0; busy = 0; pend = 0;
    m_dist = 0; m_miss = 0; m_run = 0;
    m_dv = 0; m_near = 0; m_stale = 0; m_over = 0;
  endtask

  // One clock edge of the model. A good sample enters the window one cycle after acceptance
  // and its distance appears three edges after acceptance; any sample meanwhile is dropped.
  task automatic model_step();
    bit     was_busy;
    longint sum, avg, d;
    if (reset) begin
      model_clear();
      return;
    end
    m_dv = 0;
    was_busy = (busy > 0);
    if (busy > 0) begin
      busy--;
      if (busy == 2) begin
        win[wp] = pend;
        wp = (wp + 1) % N;
        if (fill < N) fill++;
      end
      if (busy == 0 && fill == N) begin
        sum = 0;
        for (int i = 0; i < N; i++) sum += win[i];
        avg = sum / N;
        d = (avg * 225) / 65536;
        if (d > 65535) d = 65535;
        m_dist = int'(d);
        m_dv = 1;
        if (d < 300) m_near = 1;
        else if (d > 400) m_near = 0;
      end
    end
    if (bus.sample_valid) begin
      if (was_busy) m_over = 1;
      else if (bus.sample_data == 0 || bus.sample_data >= 1200000) begin
        if (m_miss < 65535) m_miss++;
        if (m_run < 8) m_run++;
        if (m_run == 8) begin
          m_stale = 1;
          m_near = 0;
        end
      end else begin
        pend = bus.sample_data;
        m_run = 0;
        m_stale = 0;
        busy = 3;
      end
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk);
      cyc++;
      model_step();
    end
  end

  // Compare every output against the model on each falling edge once reset has been seen.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("distance_mm", bus.distance_mm, m_dist);
      check("distance_valid", bus.distance_valid, m_dv);
      check("near", bus.near, m_near);
      check("stale", bus.stale, m_stale);
      check("primed", bus.primed, (fill == N));
      check("miss_count", bus.miss_count, m_miss);
      check("overrun", bus.overrun, m_over);
      if (bus.distance_valid) begin
        pulses++;
        last_pulse_cyc = cyc;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic send(input logic [31:0] data, input int gap);
    @(negedge clk);
    bus.sample_data  = data;
    bus.sample_valid = 1'b1;
    send_cyc = cyc;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    bus.sample_data  = 32'd0;
    repeat (gap - 1) @(negedge clk);
  endtask

  initial begin
    int p0;
    reset = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample_data  = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset distance_mm", bus.distance_mm, 0);
    check("reset primed", bus.primed, 0);
    check("reset miss_count", bus.miss_count, 0);

    // Fill the window with 100000: only the fourth sample produces a result.
    repeat (3) send(32'd100000, 10);
    check("no pulse before primed", pulses, 0);
    send(32'd100000, 10);
    check("first pulse", pulses, 1);
    check("latency", last_pulse_cyc - send_cyc, 4);
    check("dist 100000", bus.distance_mm, 343);
    check("primed after 4", bus.primed, 1);
    check("near at 343", bus.near, 0);

    // Walk the average down; near asserts only once the distance falls below 300.
    send(32'd80000, 10);
    check("dist avg 95000", bus.distance_mm, 326);
    check("near at 326", bus.near, 0);
    send(32'd80000, 10);
    send(32'd80000, 10);
    check("dist avg 85000", bus.distance_mm, 291);
    check("near at 291", bus.near, 1);
    send(32'd80000, 10);
    check("dist avg 80000", bus.distance_mm, 274);

    // Walk back up; near holds inside the band and drops only above 400.
    repeat (3) send(32'd120000, 10);
    check("dist avg 110000", bus.distance_mm, 377);
    check("near held at 377", bus.near, 1);
    send(32'd120000, 10);
    check("dist avg 120000", bus.distance_mm, 411);
    check("near drop at 411", bus.near, 0);

    // Re-assert near, then eight misses force stale and clear near without any pulse.
    repeat (4) send(32'd80000, 10);
    check("near before misses", bus.near, 1);
    p0 = pulses;
    repeat (7) send(32'd0, 2);
    check("stale after 7 misses", bus.stale, 0);
    send(32'd0, 2);
    check("stale after 8 misses", bus.stale, 1);
    check("near forced off", bus.near, 0);
    check("miss_count 8", bus.miss_count, 8);
    check("no pulse on misses", pulses, p0);

    // A good sample clears stale on the next cycle and reports four cycles after acceptance.
    send(32'd100000, 1);
    check("stale cleared", bus.stale, 0);
    repeat (9) @(negedge clk);
    check("pulse after stale", pulses, p0 + 1);
    check("latency after stale", last_pulse_cyc - send_cyc, 4);

    // Range boundary, then a sample during the busy window.
    send(32'd1200000, 4);
    check("miss at MAX_COUNT", bus.miss_count, 9);
    p0 = pulses;
    send(32'd1199999, 2);
    check("overrun before drop", bus.overrun, 0);
    send(32'd100000, 10);
    check("overrun sticky", bus.overrun, 1);
    check("miss_count after drop", bus.miss_count, 9);
    check("one pulse for 1199999", pulses, p0 + 1);
    check("dist with 1199999", bus.distance_mm, 1253);

    // Reset while the pipeline is in its multiply cycle.
    p0 = pulses;
    @(negedge clk);
    bus.sample_data  = 32'd100000;
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid reset distance_mm", bus.distance_mm, 0);
    check("mid reset primed", bus.primed, 0);
    check("mid reset overrun", bus.overrun, 0);
    check("mid reset miss_count", bus.miss_count, 0);
    repeat (10) @(negedge clk);
    check("no pulse after abort", pulses, p0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
